ysyx_22050243_inst_encoder: RTL
===============================

# ysyx_22050243_inst_encoder

Encodes RISC-V RV64I instructions from decoded fields: opcode, register indices, funct3/funct7, a format select and a full-width sign-extended immediate. It is the inverse of the immediate generator. For every legal request, feeding the produced instruction back into the immediate generator returns the same `imm` value. It sits in the self-test and trace-replay path, where it feeds instruction memory / IFU stimulus. Requests are buffered in a 2-entry FIFO with valid/ready handshakes on both sides.

## Interface
- `IBUS_DATA_WIDTH`, default 32: instruction width. Only 32 is supported.
- `DBUS_DATA_WIDTH`, default 64: immediate width.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: request present.
- `in_ready` output 1: request accepted when `in_valid && in_ready`.
- `in_fmt` input 6: one-hot format select, ordered {R,I,S,B,U,J} from MSB to LSB.
- `in_opcode` input 7: placed in `inst[6:0]`.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register indices.
- `in_funct3` input 3, `in_funct7` input 7: function fields.
- `in_imm` input DBUS_DATA_WIDTH: sign-extended immediate, in the same form the immediate generator produces.
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: consumer ready. Head is popped when `out_valid && out_ready`.
- `out_inst` output IBUS_DATA_WIDTH: encoded instruction.
- `out_err` output 1: the head request was illegal.
- `err_cnt` output 16: count of illegal requests accepted, saturating.
- `enc_cnt` output 32: count of requests accepted, wrapping.

## Operation
- Encoding is combinational on the input fields. The result is written into the FIFO on accept.
- Field placement by format:
  - R: `{funct7, rs2, rs1, funct3, rd, opcode}`. `in_imm` is ignored.
  - I: `{imm[11:0], rs1, funct3, rd, opcode}`.
  - S: `{imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}`.
  - B: `{imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}`.
  - U: `{imm[19:0], rd, opcode}`. The U immediate is the unshifted 20-bit field value, sign-extended, matching the immediate generator's output.
  - J: `{imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}`.
- Legality rules. Any violation is an illegal request:
  - `in_fmt` must be exactly one-hot. Zero or multiple bits set is illegal.
  - I/S: `imm[63:11]` must be all equal.
  - B: `imm[63:12]` must be all equal, and `imm[0]` must be 0.
  - U: `imm[63:19]` must be all equal.
  - J: `imm[63:20]` must be all equal, and `imm[0]` must be 0.
- Illegal requests are still accepted and occupy a FIFO slot. The stored inst is 32'h0000_0013 (NOP) and the stored err bit is 1.
- FIFO: 2 entries, with read pointer, write pointer and a 2-bit occupancy count. `in_ready = (count != 2)`.
- A simultaneous push and pop in the same cycle is legal at any occupancy, including full. When full with `out_ready=1`, `in_ready` stays 0. `in_ready` is registered-count based and never combinationally dependent on `out_ready`.
- Counters:
  - `enc_cnt` increments by 1 on every accept and wraps at 2^32.
  - `err_cnt` increments on every illegal accept and saturates at 16'hFFFF.

## Timing
- Reset values: `out_valid=0`, `in_ready=1`, `out_inst=0`, `out_err=0`, `err_cnt=0`, `enc_cnt=0`. Pointers and count are 0.
- Latency: a request accepted at edge N is visible on `out_*` after edge N, i.e. in cycle N+1, when the FIFO was empty. No combinational path from `in_*` to `out_*`.
- Throughput: 1 request per cycle while `out_ready=1`.
- Once `out_valid=1`, `out_inst`/`out_err` stay stable until popped.
- Reset asserted mid-operation flushes both entries immediately (asynchronously) and clears the counters. The first accept after deassert is at the first rising edge with `rst=0`.

## Test plan
- I-type, legal: opcode 0010011, rd=1, rs1=0, funct3=0, imm=64'hFFFF_FFFF_FFFF_FFFF -> `out_inst=32'hFFF00093`, `out_err=0`, one cycle after accept.
- S-type, legal: opcode 0100011, funct3=011, rs1=3, rs2=2, imm=8 -> `out_inst=32'h0021B423`.
- J-type, legal: opcode 1101111, rd=1, imm=64'h800 -> `out_inst=32'h001000EF`. The immediate generator's J output for this inst equals 64'h800.
- Illegal requests:
  - B-type with imm=3 -> `out_inst=32'h00000013`, `out_err=1`, `err_cnt=1`.
  - Then I-type with imm=64'h800 -> `out_inst=32'h00000013`, `out_err=1`, `err_cnt=2`.
  - Then fmt=6'b000000 -> `out_inst=32'h00000013`, `out_err=1`, `err_cnt=3`.
- Backpressure: `out_ready=0`, offer 3 back-to-back requests -> `in_ready` falls after the 2nd accept and the 3rd is held. Raise `out_ready` -> outputs appear in order, 3rd accepted on the pop cycle, `enc_cnt=3`.
- Reset mid-operation: FIFO full, assert `rst` between edges -> `out_valid` and counters drop to 0 immediately, `in_ready=1`.
- Random round-trip: 10k random legal requests -> immediate generator(`out_inst`) == `in_imm`, and `out_inst[6:0]` == `in_opcode`.

Source files
------------

// File: rtl/ysyx_22050243_inst_encoder_if.sv
// Request/response bundle for the RV64I instruction encoder.
// The master side offers decoded fields and consumes encoded instructions.
interface ysyx_22050243_inst_encoder_if #(
  parameter int IBUS_DATA_WIDTH = 32,
  parameter int DBUS_DATA_WIDTH = 64
);
  logic                       in_valid;
  logic                       in_ready;
  logic [5:0]                 in_fmt;
  logic [6:0]                 in_opcode;
  logic [4:0]                 in_rd;
  logic [4:0]                 in_rs1;
  logic [4:0]                 in_rs2;
  logic [2:0]                 in_funct3;
  logic [6:0]                 in_funct7;
  logic [DBUS_DATA_WIDTH-1:0] in_imm;
  logic                       out_valid;
  logic                       out_ready;
  logic [IBUS_DATA_WIDTH-1:0] out_inst;
  logic                       out_err;
  logic [15:0]                err_cnt;
  logic [31:0]                enc_cnt;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err, err_cnt, enc_cnt
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err, err_cnt, enc_cnt
  );
endinterface

// File: rtl/ysyx_22050243_inst_encoder.sv
// RV64I instruction encoder: packs decoded fields into a 32-bit instruction,
// buffers results in a 2-entry FIFO and keeps accept/illegal counters.
module ysyx_22050243_inst_encoder #(
  parameter int IBUS_DATA_WIDTH = 32,
  parameter int DBUS_DATA_WIDTH = 64
) (
  input logic                           clk,
  input logic                           rst,
  ysyx_22050243_inst_encoder_if.slave   bus
);

  localparam logic [IBUS_DATA_WIDTH-1:0] NOP = 32'h0000_0013;

  logic [DBUS_DATA_WIDTH-1:0] w_imm;
  logic                       w_sx11;
  logic                       w_sx12;
  logic                       w_sx19;
  logic                       w_sx20;
  logic                       w_legal;
  logic [IBUS_DATA_WIDTH-1:0] w_raw;
  logic [IBUS_DATA_WIDTH-1:0] w_enc;
  logic                       w_push;
  logic                       w_pop;

  logic [IBUS_DATA_WIDTH-1:0] r_inst [0:1];
  logic                       r_err  [0:1];
  logic                       r_wptr;
  logic                       r_rptr;
  logic [1:0]                 r_count;
  logic [15:0]                r_err_cnt;
  logic [31:0]                r_enc_cnt;

  assign w_imm = bus.in_imm;

  // Upper immediate bits must all repeat the sign bit of each format's field
  assign w_sx11 = (&w_imm[DBUS_DATA_WIDTH-1:11]) | ~(|w_imm[DBUS_DATA_WIDTH-1:11]);
  assign w_sx12 = (&w_imm[DBUS_DATA_WIDTH-1:12]) | ~(|w_imm[DBUS_DATA_WIDTH-1:12]);
  assign w_sx19 = (&w_imm[DBUS_DATA_WIDTH-1:19]) | ~(|w_imm[DBUS_DATA_WIDTH-1:19]);
  assign w_sx20 = (&w_imm[DBUS_DATA_WIDTH-1:20]) | ~(|w_imm[DBUS_DATA_WIDTH-1:20]);

  // Matching only exact one-hot codes makes zero/multi-hot selects fall to illegal
  always_comb begin
    w_raw   = NOP;
    w_legal = 1'b0;
    case (bus.in_fmt)
      6'b100000: begin
        w_raw   = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                   bus.in_rd, bus.in_opcode};
        w_legal = 1'b1;
      end
      6'b010000: begin
        w_raw   = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        w_legal = w_sx11;
      end
      6'b001000: begin
        w_raw   = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                   w_imm[4:0], bus.in_opcode};
        w_legal = w_sx11;
      end
      6'b000100: begin
        w_raw   = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                   w_imm[4:1], w_imm[11], bus.in_opcode};
        w_legal = w_sx12 & ~w_imm[0];
      end
      6'b000010: begin
        w_raw   = {w_imm[19:0], bus.in_rd, bus.in_opcode};
        w_legal = w_sx19;
      end
      6'b000001: begin
        w_raw   = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                   bus.in_rd, bus.in_opcode};
        w_legal = w_sx20 & ~w_imm[0];
      end
      default: ;
    endcase
  end

  assign w_enc = w_legal ? w_raw : NOP;

  // in_ready only looks at the registered count, so a full FIFO stays closed
  // during a pop cycle
  assign bus.in_ready  = (r_count != 2'd2);
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_inst  = bus.out_valid ? r_inst[r_rptr] : '0;
  assign bus.out_err   = bus.out_valid & r_err[r_rptr];
  assign bus.err_cnt   = r_err_cnt;
  assign bus.enc_cnt   = r_enc_cnt;

  assign w_push = bus.in_valid & bus.in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst[0] <= '0;
      r_inst[1] <= '0;
      r_err[0]  <= 1'b0;
      r_err[1]  <= 1'b0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_push) begin
        r_inst[r_wptr] <= w_enc;
        r_err[r_wptr]  <= ~w_legal;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enc_cnt <= 32'd0;
      r_err_cnt <= 16'd0;
    end else if (w_push) begin
      r_enc_cnt <= r_enc_cnt + 32'd1;
      if (!w_legal && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

endmodule
